// File: rtl/ram8_scan_if.sv
// Scan beat channel of ram8_scan: valid/ready handshake carrying one
// address/data pair per accepted beat. The master presents the beat;
// the slave is the consumer.
interface ram8_scan_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic                  scan_valid;
  logic                  scan_ready;
  logic [DEPTH_LOG2-1:0] scan_addr;
  logic [WIDTH-1:0]      scan_data;

  modport master (
    output scan_valid,
    output scan_addr,
    output scan_data,
    input  scan_ready
  );

  modport slave (
    input  scan_valid,
    input  scan_addr,
    input  scan_data,
    output scan_ready
  );
endinterface

// File: rtl/ram8_scan.sv
// ram8_scan: 8 x 16-bit register bank with one write port, a combinational
// random-access read port, and a scan sequencer that streams every word
// in address order over the ram8_scan_if beat channel.
// Optional build macro RAM8_SCAN_SKIP_ZERO_EN: when defined, words that
// read as zero during the scan are skipped instead of being presented.
module ram8_scan #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [DEPTH_LOG2-1:0] address,
  output logic [WIDTH-1:0]      out,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  ram8_scan_if.master           scan
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } state_e;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  state_e                state_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic [WIDTH-1:0]      data_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [WIDTH-1:0]      fetch_d;

  // Storage: single write per edge, cleared asynchronously on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (load) begin
      mem_q[address] <= in;
    end
  end

  // Read port is purely combinational; no bypass from the write data.
  assign out = mem_q[address];

  // Word captured in FETCH, forwarding a same-cycle write to the pointer.
  always_comb begin
    fetch_d = mem_q[ptr_q];
    if (load && (address == ptr_q)) begin
      fetch_d = in;
    end
  end

  // Scan sequencer with registered beat, busy and done outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_start) begin
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
`ifdef RAM8_SCAN_SKIP_ZERO_EN
          // Zero words never become beats; walk on or finish directly.
          if (fetch_d == '0) begin
            if (ptr_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end else begin
            data_q  <= fetch_d;
            addr_q  <= ptr_q;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
`else
          data_q  <= fetch_d;
          addr_q  <= ptr_q;
          valid_q <= 1'b1;
          state_q <= PRESENT;
`endif
        end
        PRESENT: begin
          if (scan.scan_ready) begin
            valid_q <= 1'b0;
            if (ptr_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ptr_q   <= ptr_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan.scan_valid = valid_q;
  assign scan.scan_addr  = addr_q;
  assign scan.scan_data  = data_q;
  assign scan_busy       = busy_q;
  assign scan_done       = done_q;

endmodule

// File: tb/tb_ram8_scan.sv
// Directed testbench for ram8_scan: random-access port, scan streaming,
// backpressure, FETCH forwarding, back-to-back start, mid-scan reset and
// the zero-skip build option.
module tb_ram8_scan;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;
  logic        scan_start;
  logic        scan_busy;
  logic        scan_done;
  logic        scan_ready;

  logic        valid;
  logic [2:0]  addr;
  logic [15:0] data;

  int vectors;
  int miscompares;

  int          nbeats;
  int          ndone;
  int          cycles;
  int          first_lat;
  int          hold_bad;
  logic [2:0]  b_addr [16];
  logic [15:0] b_data [16];

  ram8_scan_if #(.WIDTH(16), .DEPTH_LOG2(3)) sif ();

  ram8_scan #(.WIDTH(16), .DEPTH_LOG2(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in         (in),
    .load       (load),
    .address    (address),
    .out        (out),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .scan       (sif)
  );

  assign sif.scan_ready = scan_ready;
  assign valid = sif.scan_valid;
  assign addr  = sif.scan_addr;
  assign data  = sif.scan_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Runs one scan, recording accepted beats; optionally stalls one address.
  task automatic run_scan(input int stall_addr, input int stall_cycles,
                          input logic [15:0] stall_wr, input bit hold_start);
    int          stall_left;
    bit          stalled;
    logic [15:0] held;
    nbeats = 0; ndone = 0; hold_bad = 0; first_lat = -1;
    stall_left = stall_cycles; stalled = 1'b0; held = '0;
    scan_ready = 1'b1;
    load       = 1'b0;
    scan_start = 1'b1;
    tick();
    if (!hold_start) scan_start = 1'b0;
    cycles = 1;
    while (scan_busy && cycles < 200) begin
      load = 1'b0;
      if (valid) begin
        if (first_lat < 0) first_lat = cycles;
        if (int'(addr) == stall_addr && stall_left > 0) begin
          if (!stalled) begin
            stalled = 1'b1;
            held    = data;
          end else if (data !== held) begin
            hold_bad++;
          end
          scan_ready = 1'b0;
          stall_left--;
          load    = 1'b1;
          address = stall_addr[2:0];
          in      = stall_wr;
        end else begin
          if (stalled && int'(addr) == stall_addr && data !== held) hold_bad++;
          scan_ready = 1'b1;
          if (nbeats < 16) begin
            b_addr[nbeats] = addr;
            b_data[nbeats] = data;
          end
          nbeats++;
        end
      end
      if (scan_done) ndone++;
      tick();
      cycles++;
    end
    load       = 1'b0;
    scan_ready = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) begin
      address = i[2:0];
      #1;
      vectors++;
      if (out !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_out[%0d]: got %h expected 0000", i, out);
      end
    end
    vectors++;
    if ({scan_busy, valid, scan_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000", {scan_busy, valid, scan_done});
    end
    vectors++;
    if ({addr, data} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_beat: got addr %h data %h expected 0 0", addr, data);
    end
  endtask

  task automatic test_write_read;
    for (int i = 0; i < 8; i++) wr(i[2:0], 16'h0010 + 16'(i));
    address = 3'd5;
    #1;
    vectors++;
    if (out !== 16'h0015) begin
      miscompares++;
      $display("FAIL read5: got %h expected 0015", out);
    end
    in   = 16'hBEEF;
    load = 1'b1;
    #1;
    vectors++;
    if (out !== 16'h0015) begin
      miscompares++;
      $display("FAIL read_before_edge: got %h expected 0015", out);
    end
    tick();
    load = 1'b0;
    vectors++;
    if (out !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL read_after_edge: got %h expected beef", out);
    end
    wr(3'd5, 16'h0015);
  endtask

  task automatic test_scan;
    run_scan(-1, 0, 16'h0, 1'b0);
    vectors++;
    if (nbeats !== 8) begin
      miscompares++;
      $display("FAIL scan_beats: got %0d expected 8", nbeats);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (b_addr[i] !== i[2:0] || b_data[i] !== 16'h0010 + 16'(i)) begin
        miscompares++;
        $display("FAIL scan_beat[%0d]: got %h/%h expected %h/%h",
                 i, b_addr[i], b_data[i], i[2:0], 16'h0010 + 16'(i));
      end
    end
    vectors++;
    if (ndone !== 1) begin
      miscompares++;
      $display("FAIL scan_done_pulses: got %0d expected 1", ndone);
    end
    vectors++;
    if (cycles !== 18) begin
      miscompares++;
      $display("FAIL scan_cycles: got %0d expected 18", cycles);
    end
    vectors++;
    if (first_lat !== 2) begin
      miscompares++;
      $display("FAIL scan_latency: got %0d expected 2", first_lat);
    end
    vectors++;
    if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin
      miscompares++;
      $display("FAIL scan_idle: got busy %b done %b expected 0 0", scan_busy, scan_done);
    end
  endtask

  task automatic test_fetch_bypass;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    address = 3'd0;
    in      = 16'h1234;
    load    = 1'b1;
    tick();
    load = 1'b0;
    vectors++;
    if (valid !== 1'b1 || addr !== 3'd0 || data !== 16'h1234) begin
      miscompares++;
      $display("FAIL fetch_bypass: got v%b %h/%h expected v1 0/1234", valid, addr, data);
    end
    for (int n = 0; n < 100 && scan_busy; n++) tick();
    vectors++;
    if (scan_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_bypass_drain: got busy %b expected 0", scan_busy);
    end
  endtask

  task automatic test_backpressure;
    run_scan(3, 5, 16'hAAAA, 1'b0);
    vectors++;
    if (hold_bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d changes expected 0", hold_bad);
    end
    vectors++;
    if (nbeats !== 8 || b_addr[3] !== 3'd3 || b_data[3] !== 16'h0013) begin
      miscompares++;
      $display("FAIL bp_beat3: got n%0d %h/%h expected n8 3/0013", nbeats, b_addr[3], b_data[3]);
    end
    vectors++;
    if (ndone !== 1) begin
      miscompares++;
      $display("FAIL bp_done: got %0d expected 1", ndone);
    end
    run_scan(-1, 0, 16'h0, 1'b0);
    vectors++;
    if (b_addr[3] !== 3'd3 || b_data[3] !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL bp_rescan3: got %h/%h expected 3/aaaa", b_addr[3], b_data[3]);
    end
  endtask

  task automatic test_back_to_back;
    run_scan(-1, 0, 16'h0, 1'b1);
    vectors++;
    if (scan_busy !== 1'b0 || ndone !== 1) begin
      miscompares++;
      $display("FAIL b2b_idle: got busy %b done %0d expected 0 1", scan_busy, ndone);
    end
    tick();
    scan_start = 1'b0;
    vectors++;
    if (scan_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy %b expected 1", scan_busy);
    end
    for (int n = 0; n < 100 && scan_busy; n++) tick();
    vectors++;
    if (scan_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: got busy %b expected 0", scan_busy);
    end
  endtask

  task automatic test_reset_midscan;
    int seen_done;
    scan_ready = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int n = 0; n < 100 && !(valid && addr == 3'd4); n++) tick();
    vectors++;
    if (valid !== 1'b1 || addr !== 3'd4) begin
      miscompares++;
      $display("FAIL rst_reach_beat4: got v%b addr %h expected v1 4", valid, addr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({scan_busy, valid, scan_done} !== 3'b000 || addr !== 3'd0 || data !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_outputs: got %b %h/%h expected 000 0/0000",
               {scan_busy, valid, scan_done}, addr, data);
    end
    seen_done = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (scan_done) seen_done++;
    end
    reset_n = 1'b1;
    tick();
    if (scan_done) seen_done++;
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("FAIL rst_no_done: got %0d pulses expected 0", seen_done);
    end
    for (int i = 0; i < 8; i++) begin
      address = i[2:0];
      #1;
      vectors++;
      if (out !== 16'h0000) begin
        miscompares++;
        $display("FAIL rst_cleared[%0d]: got %h expected 0000", i, out);
      end
    end
  endtask

  task automatic test_skip_zero;
`ifdef RAM8_SCAN_SKIP_ZERO_EN
    run_scan(-1, 0, 16'h0, 1'b0);
    vectors++;
    if (nbeats !== 0 || ndone !== 1 || cycles !== 10) begin
      miscompares++;
      $display("FAIL skip_allzero: got n%0d d%0d c%0d expected n0 d1 c10", nbeats, ndone, cycles);
    end
    wr(3'd2, 16'h0002);
    wr(3'd6, 16'h0006);
    run_scan(-1, 0, 16'h0, 1'b0);
    vectors++;
    if (nbeats !== 2 || ndone !== 1) begin
      miscompares++;
      $display("FAIL skip_count: got n%0d d%0d expected n2 d1", nbeats, ndone);
    end
    vectors++;
    if (b_addr[0] !== 3'd2 || b_data[0] !== 16'h0002 ||
        b_addr[1] !== 3'd6 || b_data[1] !== 16'h0006) begin
      miscompares++;
      $display("FAIL skip_beats: got %h/%h %h/%h expected 2/0002 6/0006",
               b_addr[0], b_data[0], b_addr[1], b_data[1]);
    end
`else
    run_scan(-1, 0, 16'h0, 1'b0);
    vectors++;
    if (nbeats !== 8 || ndone !== 1 || b_addr[7] !== 3'd7 || b_data[7] !== 16'h0) begin
      miscompares++;
      $display("FAIL noskip_allzero: got n%0d d%0d %h/%h expected n8 d1 7/0000",
               nbeats, ndone, b_addr[7], b_data[7]);
    end
    wr(3'd2, 16'h0002);
    wr(3'd6, 16'h0006);
    run_scan(-1, 0, 16'h0, 1'b0);
    vectors++;
    if (nbeats !== 8 || b_data[2] !== 16'h0002 || b_data[6] !== 16'h0006 ||
        b_data[5] !== 16'h0 || b_addr[5] !== 3'd5) begin
      miscompares++;
      $display("FAIL noskip_beats: got n%0d %h %h %h/%h expected n8 0002 0006 5/0000",
               nbeats, b_data[2], b_data[6], b_addr[5], b_data[5]);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    in          = '0;
    load        = 1'b0;
    address     = '0;
    scan_start  = 1'b0;
    scan_ready  = 1'b1;
    #13;
    test_reset();
    reset_n = 1'b1;
    tick();
    test_write_read();
    test_scan();
    test_fetch_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_midscan();
    test_skip_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram8_scan.md
Name: ram8_scan

Overview:
- 8-entry x 16-bit register bank, i.e. the RAM8 stage built on the Mux8Way16 read path and the DMux8Way write decode.
- Random-access port: one write per clock, combinational read.
- Scan sequencer: on request, streams all 8 words out in address order over a valid/ready handshake.
- Sits upstream of 16-bit consumers (ALU operand path, debug dump); the read path feeds downstream logic exactly as Mux8Way16 does.

Parameters:
- WIDTH, 16, data word width.
- DEPTH_LOG2, 3, address width; depth is 2**DEPTH_LOG2 = 8 entries. Only the default is verified.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  write data.
- load  input  1  write enable; mem[address] <= in on the rising edge.
- address  input  DEPTH_LOG2  random-access read/write address.
- out  output  WIDTH  combinational read data, mem[address].
- scan_start  input  1  level-sampled scan request; acted on only in IDLE.
- scan_busy  output  1  high in every state except IDLE.
- scan_valid  output  1  scan_data/scan_addr valid.
- scan_ready  input  1  consumer accepts the beat.
- scan_addr  output  DEPTH_LOG2  address of the current beat.
- scan_data  output  WIDTH  registered word of the current beat.
- scan_done  output  1  one-cycle pulse after the last beat.

Behaviour:
- Reset (async, reset_n=0):
  - all 8 entries = 0; FSM = IDLE; ptr = 0.
  - scan_data = 0, scan_addr = 0; scan_valid, scan_busy, scan_done = 0.
  - out = 0, since it reads a cleared entry.
- Write port:
  - load=1 writes in to mem[address] at the edge.
  - out is purely combinational: it shows the old value before the edge and the new value after it. No read-during-write bypass on out.
- Writes are allowed in every FSM state, including mid-scan.
- FSM states are IDLE, FETCH, PRESENT and DONE:
  - IDLE: if scan_start=1, set ptr <= 0 and go to FETCH.
  - FETCH (1 cycle), scan_valid=0:
    - scan_data <= mem[ptr]; scan_addr <= ptr.
    - Bypass: if load=1 and address==ptr in the same cycle, scan_data <= in.
    - Next state: PRESENT.
  - PRESENT, scan_valid=1:
    - scan_data and scan_addr hold stable until scan_valid && scan_ready.
    - Writes to mem[ptr] during PRESENT do not alter the beat.
    - On handshake with ptr==7: go to DONE. Otherwise ptr <= ptr+1 and go to FETCH.
  - DONE (1 cycle): scan_done=1, scan_valid=0, then IDLE.
- scan_start is ignored outside IDLE. If held high through DONE, a new scan begins on the cycle after DONE (IDLE samples it).
- Latency:
  - scan_start to first scan_valid: 2 cycles (IDLE->FETCH->PRESENT).
  - With scan_ready tied to 1, a full scan is 1 + 8*2 + 1 = 18 cycles from the start sample to the return to IDLE.
- ptr wraps are never exercised; the sequence terminates at 7.
- Reset mid-scan aborts immediately: no scan_done pulse; memory is cleared.

Optional Feature:
- Macro: RAM8_SCAN_SKIP_ZERO_EN.
- Defined: in FETCH, if the fetched word (after bypass) is 0, no beat is presented:
  - If ptr<7: ptr <= ptr+1 and stay in FETCH.
  - If ptr==7: go to DONE.
  - An all-zero memory yields no beats, then scan_done.
  - Consumers see gaps in scan_addr.
- Undefined: all 8 entries are presented regardless of value. scan_addr on successive beats is always 0..7.

Test Plan:
1. Reset, then read address 0..7 -> out = 0x0000 for each; scan_busy=0, scan_valid=0.
2. Write mem[i] = 0x0010+i for i=0..7; read address 5 -> out = 0x0015. With load=1, address=5, in=0xBEEF, out stays 0x0015 until the edge, then shows 0xBEEF.
3. Scan with scan_ready=1 -> 8 beats: scan_addr 0..7, scan_data 0x0010..0x0017. scan_done pulses exactly 1 cycle; total 18 cycles; scan_busy drops after DONE.
4. Backpressure: hold scan_ready=0 for 5 cycles on beat 3 and write mem[3]=0xAAAA meanwhile -> scan_data stays 0x0013 until accepted. A later scan shows 0xAAAA at address 3.
5. Assert reset_n=0 during beat 4 -> outputs drop immediately to reset values with no scan_done; after release, every out reads 0x0000.
6. With RAM8_SCAN_SKIP_ZERO_EN and only mem[2]=0x0002, mem[6]=0x0006 nonzero -> exactly 2 beats (addr 2, addr 6), then scan_done. With all-zero memory -> 0 beats and scan_done.
